// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1/8N2 UART transmitter. It takes its requests from a held config word
// using a level toggle handshake and reports busy, ack, pending and a frame count.
module uart_tx_mmio #(
  parameter int STOP_BITS = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] config_reg,
  output logic [31:0] status_reg,
  output logic        tx
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  state_t      state_q;
  logic [7:0]  shift_q;
  logic [15:0] div_q;
  logic [15:0] cnt_q;
  logic [3:0]  bit_q;
  logic        ack_q;
  logic        busy_q;
  logic        tx_q;
  logic [7:0]  frames_q;

  logic        pending;
  logic        bit_end;

  // The request is level based, so it stays pending until the toggle is acknowledged.
  assign pending = (config_reg[8] != ack_q);
  assign bit_end = (cnt_q == div_q - 16'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      shift_q  <= 8'd0;
      div_q    <= 16'd0;
      cnt_q    <= 16'd0;
      bit_q    <= 4'd0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      tx_q     <= 1'b1;
      frames_q <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pending) begin
            shift_q <= config_reg[7:0];
            div_q   <= (config_reg[31:16] == 16'd0) ? 16'd1 : config_reg[31:16];
            ack_q   <= config_reg[8];
            bit_q   <= 4'd0;
            cnt_q   <= 16'd0;
            busy_q  <= 1'b1;
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (bit_end) begin
            cnt_q   <= 16'd0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt_q   <= 16'd0;
            shift_q <= shift_q >> 1;
            if (bit_q == 4'd7) begin
              bit_q   <= 4'd0;
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_q <= bit_q + 4'd1;
              tx_q  <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt_q <= 16'd0;
            if (bit_q == LAST_STOP) begin
              bit_q    <= 4'd0;
              busy_q   <= 1'b0;
              frames_q <= frames_q + 8'd1;
              state_q  <= IDLE;
            end else begin
              bit_q <= bit_q + 4'd1;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx         = tx_q;
  assign status_reg = {16'd0, frames_q, 5'd0, pending, ack_q, busy_q};

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter that consumes the configuration word (data word 10) driven out of data memory and produces the status word returned on reads of data word 11. Software writes a byte, a bit-period divisor and a send toggle into the config word with `sw`, then polls the status word with `lw`. The block serialises the byte onto a single `tx` line as 8N1 (or 8N2) frames.

## Interface
- `STOP_BITS`, default 1: number of stop bits per frame; legal values 1 or 2.
- `clk`  input  1  system clock, shared with the processor and data memory.
- `reset`  input  1  asynchronous, active-high reset.
- `config_reg`  input  32  config word from data memory.
  - [7:0] tx byte.
  - [8] send toggle.
  - [15:9] ignored.
  - [31:16] bit period in clk cycles.
- `status_reg`  output  32  status word to data memory.
  - [0] busy.
  - [1] ack toggle.
  - [2] pending.
  - [7:3] zero.
  - [15:8] frame count.
  - [31:16] zero.
- `tx`  output  1  serial line, idle high.

## Operation
- **Request handshake:** level-based toggle, because `config_reg` is a held memory word.
  - A request is pending whenever `config_reg[8] != ack`.
  - `pending = (config_reg[8] != ack)` is combinational and drives `status_reg[2]`.
- **States:** IDLE, START, DATA, STOP.
- **IDLE:**
  - `tx`=1, busy=0.
  - On a rising edge with a request pending, in the same edge:
    - latch byte = `config_reg[7:0]`;
    - latch div = `config_reg[31:16]`, with 0 treated as 1;
    - ack <= `config_reg[8]`;
    - bit counter <= 0, period counter <= 0;
    - state <= START.
- **START:** `tx`=0 for div cycles, then DATA.
- **DATA:**
  - `tx` = shift register LSB, sent LSB-first.
  - Each bit is held div cycles.
  - After bit 7 completes, go to STOP.
- **STOP:**
  - `tx`=1 for `STOP_BITS`×div cycles, then IDLE.
  - frame count increments by 1, 8-bit wrap 255→0, on the IDLE-entering edge.
- **busy:** 1 in every state except IDLE.
- **Period counter:** 16 bits, counts 0..div-1; the bit boundary occurs on the edge where counter == div-1.
- **Mid-frame config changes:** changes to `config_reg` during a frame do not affect it, because byte and div are latched.
- **Toggle flipped while busy:** pending stays 1 and the request is accepted on the first edge in IDLE. The next frame starts with no idle gap beyond the IDLE cycle.
- **Toggle flipped twice while busy:** pending returns to 0 and the request is lost. This is documented software responsibility.
- **Reset (asynchronous), including mid-frame:**
  - state=IDLE, `tx`=1, ack=0, frame count=0;
  - counters=0, shift register=0.
  - No partial frame resumes.
- **Reset with `config_reg[8]`=1** (memory init image): a frame starts on the first edge after reset deassertion. Software initialises bit 8 to 0.
- All outputs except `status_reg[2]` are registered.

## Timing
- **Request accept:** `sw` updates `config_reg` at edge E0. The request is accepted at edge E1 when IDLE.
  - At E1, `tx` falls and busy/ack update.
- **Frame length:** 9 + `STOP_BITS` bit periods.
  - = (9+`STOP_BITS`)×div cycles from E1 to the edge where busy drops.
  - div=4, `STOP_BITS`=1: busy high 40 cycles.
- **Back-to-back frames:** minimum spacing between frames is (9+`STOP_BITS`)×div + 1 cycles.
- **div=1:** each bit lasts exactly one cycle.
- **status_reg latency:** reflects state the cycle after each edge. A `lw` in the same cycle as the accepting edge reads pre-edge values.

## Test plan
- **Reset mid-frame:** assert reset asynchronously (between clock edges) mid-frame → `tx`=1 and `status_reg`=0 immediately.
  - Then after reset release, with `config_reg[8]`=0 → `tx` stays 1 and no frame starts.
- **Basic frame:** `config_reg`=0x0004_0155 (byte 0x55, toggle 1, div 4) → starting one edge later, `tx` shows:
  - start bit 0 for 4 cycles;
  - data bits 1,0,1,0,1,0,1,0, each 4 cycles;
  - stop bit 1 for 4 cycles.
  - busy high 40 cycles; `status_reg` then 0x0000_0102 (count 1, ack 1, busy 0).
- **div=0 edge case:** byte 0xA3, toggle 0 after the previous frame → 1-cycle bits.
  - `tx` = 0,1,1,0,0,0,1,0,1,1.
  - Frame takes 10 cycles.
- **Queued request:** flip the toggle while busy → pending=1 during the frame.
  - Next frame starts exactly one cycle after busy falls.
  - Also change byte/div mid-frame → current frame bits unchanged.
- **Counter wrap:** send 256 frames → frame count wraps to 0x00 and ack equals the last toggle.
- **STOP_BITS=2:** div=3 → stop high 6 cycles; busy high 33 cycles.
